// File: rtl/approx_err_monitor.sv
// Error-distance monitor for an approximate 32x32 multiplier.
// Optional max-error tracking: define APPROX_MAX_ERR_EN.
module approx_err_monitor (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] p_approx,
  output logic        ed_valid,
  output logic [63:0] ed,
  output logic [31:0] sample_cnt,
  output logic [31:0] err_cnt,
  output logic [79:0] sum_ed,
  output logic [63:0] max_ed,
  output logic [31:0] max_a,
  output logic [31:0] max_b
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    CMP
  } state_e;

  state_e      state_q;
  logic        rdy_q;
  logic [5:0]  cnt_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_q;
  logic [63:0] pa_q;
  logic        edv_q;
  logic [63:0] ed_q;
  logic [31:0] smp_q;
  logic [31:0] err_q;
  logic [79:0] sum_q;

  logic [63:0] ed_d;
  logic [80:0] sum_ext;
  logic [79:0] sum_d;
  logic [31:0] smp_d;
  logic [31:0] err_d;

  // Error distance and saturating statistic updates for the CMP cycle
  always_comb begin
    ed_d    = (acc_q >= pa_q) ? (acc_q - pa_q)
                              : (pa_q - acc_q);
    sum_ext = {1'b0, sum_q} + {17'b0, ed_d};
    sum_d   = sum_ext[80] ? {80{1'b1}} : sum_ext[79:0];
    smp_d   = (&smp_q) ? smp_q : smp_q + 32'd1;
    err_d   = err_q;
    if (ed_d != 64'd0 && !(&err_q))
      err_d = err_q + 32'd1;
  end

  // Control FSM, shift-add multiplier and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      pa_q     <= '0;
      edv_q    <= 1'b0;
      ed_q     <= '0;
      smp_q    <= '0;
      err_q    <= '0;
      sum_q    <= '0;
    end else begin
      edv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= {32'd0, a};
            mplier_q <= b;
            acc_q    <= '0;
            pa_q     <= p_approx;
            cnt_q    <= '0;
            state_q  <= MUL;
            rdy_q    <= 1'b0;
          end
        end
        MUL: begin
          // cnt_q[5] set means all 32 bits consumed
          if (cnt_q[5]) begin
            state_q <= CMP;
          end else begin
            if (mplier_q[0])
              acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 6'd1;
          end
        end
        CMP: begin
          ed_q    <= ed_d;
          edv_q   <= 1'b1;
          smp_q   <= smp_d;
          err_q   <= err_d;
          sum_q   <= sum_d;
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = rdy_q;
  assign ed_valid   = edv_q;
  assign ed         = ed_q;
  assign sample_cnt = smp_q;
  assign err_cnt    = err_q;
  assign sum_ed     = sum_q;

`ifdef APPROX_MAX_ERR_EN
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] max_q;
  logic [31:0] max_a_q;
  logic [31:0] max_b_q;

  // Track strictly larger error; ties keep the earlier operands
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      max_q   <= '0;
      max_a_q <= '0;
      max_b_q <= '0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        a_q <= a;
        b_q <= b;
      end
      if (state_q == CMP && ed_d > max_q) begin
        max_q   <= ed_d;
        max_a_q <= a_q;
        max_b_q <= b_q;
      end
    end
  end

  assign max_ed = max_q;
  assign max_a  = max_a_q;
  assign max_b  = max_b_q;
`else
  assign max_ed = '0;
  assign max_a  = '0;
  assign max_b  = '0;
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor.
// Max-error expectations follow APPROX_MAX_ERR_EN.
module tb_approx_err_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [63:0] p_approx = '0;
  logic        ed_valid;
  logic [63:0] ed;
  logic [31:0] sample_cnt;
  logic [31:0] err_cnt;
  logic [79:0] sum_ed;
  logic [63:0] max_ed;
  logic [31:0] max_a;
  logic [31:0] max_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_acc = 0;

  approx_err_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .p_approx   (p_approx),
    .ed_valid   (ed_valid),
    .ed         (ed),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed),
    .max_a      (max_a),
    .max_b      (max_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef APPROX_MAX_ERR_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  // Present one triple; returns #1 after the accepting edge.
  task automatic start_triple(input logic [31:0] ta,
                              input logic [31:0] tb,
                              input logic [63:0] tp,
                              output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    a = ta;
    b = tb;
    p_approx = tp;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    t_acc = cyc;
    in_valid = 1'b0;
  endtask

  // Wait for ed_valid; lat is edges since the accepting edge.
  task automatic wait_edv(output bit found, output int lat);
    found = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (ed_valid) begin
        found = 1'b1;
        lat = cyc - t_acc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (in_ready !== 1'b1 || ed_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs: rdy=%b edv=%b want 1/0",
               in_ready, ed_valid);
    end
    n_cmp++;
    if (ed !== 64'd0 || sample_cnt !== 32'd0 ||
        err_cnt !== 32'd0 || sum_ed !== 80'd0 ||
        max_ed !== 64'd0 || max_a !== 32'd0 ||
        max_b !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_stats: ed=%h s=%0d e=%0d sum=%h mx=%h want 0",
               ed, sample_cnt, err_cnt, sum_ed, max_ed);
    end
  endtask

  task automatic test_exact();
    bit ok, f;
    int lat;
    do_reset();
    start_triple(32'd3, 32'd5, 64'd15, ok);
    wait_edv(f, lat);
    n_cmp++;
    if (!ok || !f || lat != 34) begin
      n_bad++;
      $display("FAIL exact_lat: ok=%b found=%b lat=%0d want 34",
               ok, f, lat);
    end
    n_cmp++;
    if (ed !== 64'd0 || sample_cnt !== 32'd1 ||
        err_cnt !== 32'd0 || sum_ed !== 80'd0) begin
      n_bad++;
      $display("FAIL exact_val: ed=%h s=%0d e=%0d sum=%h want 0/1/0/0",
               ed, sample_cnt, err_cnt, sum_ed);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (ed_valid !== 1'b0 || ed !== 64'd0) begin
      n_bad++;
      $display("FAIL exact_strobe: edv=%b ed=%h want 0/0",
               ed_valid, ed);
    end
  endtask

  task automatic test_errors();
    bit ok, f;
    int lat;
    do_reset();
    start_triple(32'd3, 32'd5, 64'd13, ok);
    wait_edv(f, lat);
    n_cmp++;
    if (!f || ed !== 64'd2) begin
      n_bad++;
      $display("FAIL err_first: found=%b ed=%h want 2", f, ed);
    end
    start_triple(32'd2, 32'd2, 64'd7, ok);
    wait_edv(f, lat);
    n_cmp++;
    if (!f || ed !== 64'd3) begin
      n_bad++;
      $display("FAIL err_second: found=%b ed=%h want 3", f, ed);
    end
    n_cmp++;
    if (sum_ed !== 80'd5 || err_cnt !== 32'd2 ||
        sample_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL err_stats: sum=%h e=%0d s=%0d want 5/2/2",
               sum_ed, err_cnt, sample_cnt);
    end
    n_cmp++;
    if (max_ed !== (MAXEN ? 64'd3 : 64'd0) ||
        max_a !== (MAXEN ? 32'd2 : 32'd0) ||
        max_b !== (MAXEN ? 32'd2 : 32'd0)) begin
      n_bad++;
      $display("FAIL err_max: mx=%h ma=%h mb=%h maxen=%b",
               max_ed, max_a, max_b, MAXEN);
    end
  endtask

  task automatic test_boundary();
    bit ok, f;
    int lat;
    start_triple(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, ok);
    wait_edv(f, lat);
    n_cmp++;
    if (!f || ed !== 64'hFFFF_FFFE_0000_0001) begin
      n_bad++;
      $display("FAIL bound_ed: found=%b ed=%h want fffffffe00000001",
               f, ed);
    end
    n_cmp++;
    if (sum_ed !== 80'h0000_FFFF_FFFE_0000_0006 ||
        err_cnt !== 32'd3 || sample_cnt !== 32'd3) begin
      n_bad++;
      $display("FAIL bound_stats: sum=%h e=%0d s=%0d",
               sum_ed, err_cnt, sample_cnt);
    end
    n_cmp++;
    if (max_ed !== (MAXEN ? 64'hFFFF_FFFE_0000_0001 : 64'd0) ||
        max_a !== (MAXEN ? 32'hFFFF_FFFF : 32'd0) ||
        max_b !== (MAXEN ? 32'hFFFF_FFFF : 32'd0)) begin
      n_bad++;
      $display("FAIL bound_max: mx=%h ma=%h mb=%h maxen=%b",
               max_ed, max_a, max_b, MAXEN);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, f;
    int lat;
    do_reset();
    start_triple(32'd10, 32'd10, 64'd90, ok);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_busy: rdy=%b want 0", in_ready);
    end
    a = 32'd7;
    b = 32'd7;
    p_approx = 64'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_edv(f, lat);
    n_cmp++;
    if (!f || lat != 34 || ed !== 64'd10) begin
      n_bad++;
      $display("FAIL b2b_first: found=%b lat=%0d ed=%h want 34/a",
               f, lat, ed);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: rdy=%b want 1", in_ready);
    end
    start_triple(32'd4, 32'd4, 64'd20, ok);
    n_cmp++;
    if (ed_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept: edv=%b rdy=%b want 0/0",
               ed_valid, in_ready);
    end
    wait_edv(f, lat);
    n_cmp++;
    if (!f || lat != 34 || ed !== 64'd4) begin
      n_bad++;
      $display("FAIL b2b_second: found=%b lat=%0d ed=%h want 34/4",
               f, lat, ed);
    end
    n_cmp++;
    if (sample_cnt !== 32'd2 || err_cnt !== 32'd2 ||
        sum_ed !== 80'd14) begin
      n_bad++;
      $display("FAIL b2b_stats: s=%0d e=%0d sum=%h want 2/2/e",
               sample_cnt, err_cnt, sum_ed);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    start_triple(32'd9, 32'd9, 64'd1, ok);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_ready: rdy=%b want 1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ed_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL mid_edv: ed_valid seen=%b want 0", seen);
    end
    n_cmp++;
    if (sample_cnt !== 32'd0 || err_cnt !== 32'd0 ||
        sum_ed !== 80'd0 || ed !== 64'd0 ||
        max_ed !== 64'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_stats: s=%0d e=%0d sum=%h ed=%h mx=%h rdy=%b",
               sample_cnt, err_cnt, sum_ed, ed, max_ed, in_ready);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_exact();
    test_errors();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
